// File: rtl/forward_hazard_ctrl_if.sv
// rtl/forward_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
// master: pipeline side driving register ids and controls; slave: the hazard controller.
interface forward_hazard_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC*REG_AW-1:0] ex_src_addr;
  logic [NUM_SRC*REG_AW-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_ex_RegD;
  logic                      id_ex_RegWrite;
  logic                      id_ex_MemRead;
  logic                      id_ex_MulOp;
  logic [REG_AW-1:0]         ex_m_RegD;
  logic                      ex_m_RegWrite;
  logic [REG_AW-1:0]         mem_wb_RegD;
  logic                      mem_wb_RegWrite;
  logic                      ex_flush;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall;
  logic                      bubble_ex;
  logic                      bubble_mem;

  modport master (
    output ex_src_addr, id_src_addr, id_src_used,
    output id_ex_RegD, id_ex_RegWrite, id_ex_MemRead, id_ex_MulOp,
    output ex_m_RegD, ex_m_RegWrite, mem_wb_RegD, mem_wb_RegWrite, ex_flush,
    input  fwd_sel, stall, bubble_ex, bubble_mem
  );

  modport slave (
    input  ex_src_addr, id_src_addr, id_src_used,
    input  id_ex_RegD, id_ex_RegWrite, id_ex_MemRead, id_ex_MulOp,
    input  ex_m_RegD, ex_m_RegWrite, mem_wb_RegD, mem_wb_RegWrite, ex_flush,
    output fwd_sel, stall, bubble_ex, bubble_mem
  );
endinterface

// File: rtl/forward_hazard_ctrl.sv
// rtl/forward_hazard_ctrl.sv - operand forwarding, load-use and multi-cycle multiply hazard control
// Optional stall statistics counter enabled by FWD_STALL_STATS_EN.
module forward_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  forward_hazard_ctrl_if.slave hz
`ifdef FWD_STALL_STATS_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);
  localparam int CW = $clog2(MUL_LAT) + 1;
  // First hold cycle is spent in IDLE, so the busy phase covers MUL_LAT-2 more.
  localparam logic [CW-1:0] CNT_LOAD = (MUL_LAT > 1) ? CW'(MUL_LAT - 2) : '0;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t         state, stateNext;
  logic [CW-1:0]  cnt, cntNext;
  logic           mulHold;
  logic           loadUse;

  always_comb begin
    hz.fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hz.ex_m_RegWrite && hz.ex_m_RegD != '0 &&
          hz.ex_m_RegD == hz.ex_src_addr[i*REG_AW +: REG_AW])
        hz.fwd_sel[2*i +: 2] = 2'b10;
      else if (hz.mem_wb_RegWrite && hz.mem_wb_RegD != '0 &&
               hz.mem_wb_RegD == hz.ex_src_addr[i*REG_AW +: REG_AW])
        hz.fwd_sel[2*i +: 2] = 2'b01;
    end
  end

  always_comb begin
    loadUse = 1'b0;
    if (hz.id_ex_MemRead && hz.id_ex_RegWrite && hz.id_ex_RegD != '0) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (hz.id_src_used[i] && hz.id_src_addr[i*REG_AW +: REG_AW] == hz.id_ex_RegD)
          loadUse = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (hz.ex_flush) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (hz.id_ex_MulOp && MUL_LAT > 1) begin
            stateNext = MUL_BUSY;
            cntNext   = CNT_LOAD;
          end
        end
        MUL_BUSY: begin
          if (cnt != '0) cntNext = cnt - CW'(1);
          else           stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // rst_n gates the hold so a reset mid-multiply releases the pipeline immediately.
  always_comb begin
    mulHold       = 1'b0;
    hz.stall      = 1'b0;
    hz.bubble_ex  = 1'b0;
    hz.bubble_mem = 1'b0;
    if (rst_n && !hz.ex_flush) begin
      case (state)
        IDLE:     mulHold = hz.id_ex_MulOp && (MUL_LAT > 1);
        MUL_BUSY: mulHold = (cnt != '0);
        default:  mulHold = 1'b0;
      endcase
    end
    if (mulHold) begin
      hz.stall      = 1'b1;
      hz.bubble_mem = 1'b1;
    end else if (loadUse && !hz.ex_flush) begin
      hz.stall      = 1'b1;
      hz.bubble_ex  = 1'b1;
    end
  end

`ifdef FWD_STALL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (hz.stall && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/forward_hazard_ctrl.md
FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register address width.
REQ-002 SHALL have parameter NUM_SRC, default 2: number of source operands per instruction.
REQ-003 SHALL have parameter MUL_LAT, default 3: EX-stage cycles per multiply, at least 1.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port ex_src_addr, input, NUM_SRC*REG_AW: EX-stage source registers; source i at bits [(i+1)*REG_AW-1 : i*REG_AW].
REQ-007 SHALL have port id_src_addr, input, NUM_SRC*REG_AW: ID-stage source registers, packed the same way.
REQ-008 SHALL have port id_src_used, input, NUM_SRC: ID source i is actually read.
REQ-009 SHALL have ports id_ex_RegD (REG_AW), id_ex_RegWrite (1), id_ex_MemRead (1) and id_ex_MulOp (1), all inputs: ID/EX destination and control.
REQ-010 SHALL have ports ex_m_RegD (REG_AW), ex_m_RegWrite (1), mem_wb_RegD (REG_AW) and mem_wb_RegWrite (1), all inputs: later-stage writers.
REQ-011 SHALL have port ex_flush, input, 1: EX contents squashed this cycle.
REQ-012 SHALL have port fwd_sel, output, 2*NUM_SRC: forward select, source i at bits [2i+1:2i].
REQ-013 SHALL have ports stall, bubble_ex and bubble_mem, outputs, 1 each: hold PC/IF-ID; zero ID/EX controls; zero EX/MEM controls.

Function
REQ-014 fwd_sel[i] SHALL be 2'b10 when ex_m_RegWrite=1, ex_m_RegD!=0 and ex_m_RegD equals ex source i.
REQ-015 Otherwise fwd_sel[i] SHALL be 2'b01 when mem_wb_RegWrite=1, mem_wb_RegD!=0 and mem_wb_RegD equals ex source i; otherwise 2'b00; EX/MEM has priority over MEM/WB.
REQ-016 fwd_sel SHALL be combinational with zero latency and independent of FSM state.
REQ-017 The FSM SHALL have states IDLE and MUL_BUSY plus a down-counter cnt of width clog2(MUL_LAT)+1.
REQ-018 In IDLE with id_ex_MulOp=1, MUL_LAT>1 and ex_flush=0: mul_hold=1 this cycle; next state MUL_BUSY; cnt loads MUL_LAT-2.
REQ-019 In MUL_BUSY: mul_hold=(cnt!=0); cnt decrements while nonzero; the next state is IDLE when cnt==0.
REQ-020 Each multiply SHALL therefore hold exactly MUL_LAT-1 cycles, with no retrigger on the same multiply.
REQ-021 With MUL_LAT=1, mul_hold SHALL never assert and the FSM SHALL stay in IDLE.
REQ-022 ex_flush=1 SHALL force mul_hold=0 in the same cycle and next state IDLE, with cnt=0 and precedence over REQ-018 and REQ-019.
REQ-023 load_use SHALL be 1 when id_ex_MemRead=1, id_ex_RegWrite=1, id_ex_RegD!=0 and, for some i, id_src_used[i]=1 and ID source i equals id_ex_RegD.
REQ-024 When mul_hold=1, outputs SHALL be stall=1, bubble_mem=1 and bubble_ex=0; load_use is ignored because ID is frozen.
REQ-025 When mul_hold=0 and load_use=1, outputs SHALL be stall=1, bubble_ex=1 and bubble_mem=0, for one cycle per occurrence.
REQ-026 When mul_hold=0 and load_use=0 and ex_flush=0, outputs SHALL be stall=0, bubble_ex=0 and bubble_mem=0.
REQ-027 ex_flush=1 SHALL suppress load_use, forcing stall=0 and bubble_ex=0.
REQ-028 Register 0 SHALL never cause forwarding, load-use or scoreboard effects.

Reset
REQ-029 rst_n=0 SHALL immediately set state=IDLE and cnt=0, and clear the statistics counter when present.
REQ-030 Reset asserted during MUL_BUSY SHALL drop mul_hold in the same cycle; after release, the first edge evaluates from IDLE.
REQ-031 Out of reset, with all inputs 0: fwd_sel=0, stall=0, bubble_ex=0, bubble_mem=0.

Configuration
REQ-032 With macro FWD_STALL_STATS_EN defined: add output stall_cnt [15:0], incremented on every clk edge where stall=1, saturating at 16'hFFFF, cleared by reset.
REQ-033 Without FWD_STALL_STATS_EN: no stall_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-034 ex src0=3, ex_m_RegD=3 with write=1, mem_wb_RegD=3 with write=1 -> fwd_sel[1:0]=2'b10; drop ex_m_RegWrite -> 2'b01; set both RegD=0 -> 2'b00.
REQ-035 id_ex load writing r5, ID src1=5 with used=1 -> stall=1 and bubble_ex=1 for exactly 1 cycle; same with id_src_used[1]=0 -> no stall.
REQ-036 MUL_LAT=3, multiply enters EX at cycle T -> stall=1 and bubble_mem=1 at T and T+1, 0 at T+2, state IDLE at T+3; MUL_LAT=1 -> no stall.
REQ-037 MUL_LAT=4, ex_flush=1 at T+1 -> stall=0 from T+1; a new multiply at T+2 holds 3 full cycles.
REQ-038 rst_n=0 pulse mid-MUL_BUSY -> stall=0 asynchronously; with FWD_STALL_STATS_EN, stall_cnt=0, and 70000 forced stall cycles -> stall_cnt=16'hFFFF.
